// File: rtl/ram2_port_arbiter_pkg.sv
// Shared definitions for the two-client RAM2 port arbiter: default widths,
// client indices and write-lock FSM state encoding.
package ram2_port_arbiter_pkg;

    localparam int ADDR_W_DEF    = 5;
    localparam int DATA_W_DEF    = 32;
    localparam int MAX_BURST_DEF = 4;
    localparam int CNT_W         = 4;

    localparam int CLIENT0 = 0;
    localparam int CLIENT1 = 1;

    localparam logic [0:0] W_FREE   = 1'b0;
    localparam logic [0:0] W_LOCKED = 1'b1;

endpackage

// File: rtl/ram2_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with an optional forced winner.
// The forced winner only takes the grant while it is actually requesting;
// otherwise plain round-robin against 'last' applies.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       force_valid,
    input  logic       force_idx,
    output logic [1:0] gnt
);

    // one-hot (or zero) grant from requests, force and last winner
    always_comb begin
        gnt = 2'b00;
        if (force_valid && req[force_idx]) begin
            gnt[force_idx] = 1'b1;
        end else if (&req) begin
            gnt[!last] = 1'b1;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ram2_port_arbiter.sv
// Shares RAM2's write port and read port 0 between two kernel clients.
// Write and read channels are arbitrated independently; the write channel
// additionally supports bounded locked bursts for one client.
module ram2_port_arbiter
    import ram2_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          c_wvalid,
    input  logic [1:0]          c_wlock,
    input  logic [2*ADDR_W-1:0] c_waddr,
    input  logic [2*DATA_W-1:0] c_wdata,
    output logic [1:0]          c_wready,
    input  logic [1:0]          c_rvalid,
    input  logic [2*ADDR_W-1:0] c_raddr,
    output logic [1:0]          c_rready,
    output logic [DATA_W-1:0]   c_rdata,
    output logic [1:0]          c_rdata_valid,
    output logic [ADDR_W-1:0]   ram_waddr_0,
    output logic [DATA_W-1:0]   ram_wdata_0,
    output logic                ram_wen_0,
    output logic [ADDR_W-1:0]   ram_raddr_0,
    input  logic [DATA_W-1:0]   ram_rdata_0
);

    localparam logic [CNT_W:0] BURST_LIM = (CNT_W+1)'(MAX_BURST);

    logic             last_w_q, last_w_d;
    logic             last_r_q, last_r_d;
    logic [1:0]       rsp_owner_q;
    logic [0:0]       wstate_q, wstate_d;
    logic             wowner_q, wowner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] wgnt, rgnt;
    logic       wfire, wfire_idx, wsel;
    logic       rfire, rfire_idx, rsel;
    logic       lock_hold;

    rr_arb2 u_warb (
        .req         (c_wvalid),
        .last        (last_w_q),
        .force_valid (wstate_q == W_LOCKED),
        .force_idx   (wowner_q),
        .gnt         (wgnt)
    );

    rr_arb2 u_rarb (
        .req         (c_rvalid),
        .last        (last_r_q),
        .force_valid (1'b0),
        .force_idx   (1'b0),
        .gnt         (rgnt)
    );

    // grants are suppressed while reset is held; idle muxes hold the last winner
    always_comb begin
        c_wready    = rst ? wgnt : 2'b00;
        c_rready    = rst ? rgnt : 2'b00;
        wfire       = |c_wready;
        wfire_idx   = c_wready[1];
        rfire       = |c_rready;
        rfire_idx   = c_rready[1];
        wsel        = wfire ? wfire_idx : last_w_q;
        rsel        = rfire ? rfire_idx : last_r_q;
        ram_wen_0   = wfire;
        ram_waddr_0 = wsel ? c_waddr[CLIENT1*ADDR_W +: ADDR_W] : c_waddr[CLIENT0*ADDR_W +: ADDR_W];
        ram_wdata_0 = wsel ? c_wdata[CLIENT1*DATA_W +: DATA_W] : c_wdata[CLIENT0*DATA_W +: DATA_W];
        ram_raddr_0 = rsel ? c_raddr[CLIENT1*ADDR_W +: ADDR_W] : c_raddr[CLIENT0*ADDR_W +: ADDR_W];
        c_rdata       = ram_rdata_0;
        c_rdata_valid = rsp_owner_q;
        last_w_d    = wfire ? wfire_idx : last_w_q;
        last_r_d    = rfire ? rfire_idx : last_r_q;
    end

    // write lock FSM: continue, release, or start a locked burst
    always_comb begin
        wstate_d  = W_FREE;
        wowner_d  = wowner_q;
        cnt_d     = '0;
        lock_hold = (wstate_q == W_LOCKED) && c_wvalid[wowner_q];
        if (lock_hold) begin
            if (c_wlock[wowner_q] && (({1'b0, cnt_q} + 1'b1) < BURST_LIM)) begin
                wstate_d = W_LOCKED;
                cnt_d    = cnt_q + 1'b1;
            end
        end else if (wfire && c_wlock[wfire_idx] && (BURST_LIM > 1)) begin
            wstate_d = W_LOCKED;
            wowner_d = wfire_idx;
            cnt_d    = 1;
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_w_q    <= 1'b1;
            last_r_q    <= 1'b1;
            rsp_owner_q <= 2'b00;
            wstate_q    <= W_FREE;
            wowner_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            last_w_q    <= last_w_d;
            last_r_q    <= last_r_d;
            rsp_owner_q <= c_rvalid & c_rready;
            wstate_q    <= wstate_d;
            wowner_q    <= wowner_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ram2_port_arbiter.sv
// Directed bench for ram2_port_arbiter with a behavioural RAM2 model
// (registered read, 1-cycle latency) on the arbitrated ports.
module tb_ram2_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    c_wvalid, c_wlock, c_wready, c_rvalid, c_rready, c_rdata_valid;
    logic [2*AW-1:0] c_waddr, c_raddr;
    logic [2*DW-1:0] c_wdata;
    logic [DW-1:0] c_rdata, ram_wdata_0, ram_rdata_0;
    logic [AW-1:0] ram_waddr_0, ram_raddr_0;
    logic          ram_wen_0;

    logic [DW-1:0] mem [32] = '{default: '0};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram2_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .c_wvalid(c_wvalid), .c_wlock(c_wlock), .c_waddr(c_waddr), .c_wdata(c_wdata),
        .c_wready(c_wready),
        .c_rvalid(c_rvalid), .c_raddr(c_raddr), .c_rready(c_rready),
        .c_rdata(c_rdata), .c_rdata_valid(c_rdata_valid),
        .ram_waddr_0(ram_waddr_0), .ram_wdata_0(ram_wdata_0), .ram_wen_0(ram_wen_0),
        .ram_raddr_0(ram_raddr_0), .ram_rdata_0(ram_rdata_0)
    );

    always @(posedge clk) begin
        if (ram_wen_0) mem[ram_waddr_0] <= ram_wdata_0;
        ram_rdata_0 <= mem[ram_raddr_0];
    end

    typedef struct {
        logic          rst;
        logic [1:0]    wv, wl;
        logic [AW-1:0] wa0, wa1;
        logic [DW-1:0] wd0, wd1;
        logic [1:0]    rv;
        logic [AW-1:0] ra0, ra1;
        logic [1:0]    ewr, err;
        logic [AW-1:0] ewaddr;
        logic [DW-1:0] ewdata;
        logic [AW-1:0] eraddr;
        logic          chk_rdv;
        logic [1:0]    erdv;
        logic [DW-1:0] erdata;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [1:0] wv, input logic [1:0] wl,
                       input int wa0, input int wd0, input int wa1, input int wd1,
                       input logic [1:0] rv, input int ra0, input int ra1,
                       input logic [1:0] ewr, input logic [1:0] err, input int ewa, input int ewd,
                       input int era, input logic crdv, input logic [1:0] erdv, input int erd);
        vec_t v;
        v.rst = r; v.wv = wv; v.wl = wl;
        v.wa0 = AW'(wa0); v.wd0 = DW'(wd0); v.wa1 = AW'(wa1); v.wd1 = DW'(wd1);
        v.rv = rv; v.ra0 = AW'(ra0); v.ra1 = AW'(ra1);
        v.ewr = ewr; v.err = err; v.ewaddr = AW'(ewa); v.ewdata = DW'(ewd);
        v.eraddr = AW'(era); v.chk_rdv = crdv; v.erdv = erdv; v.erdata = DW'(erd);
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst      = v.rst;
        c_wvalid = v.wv;
        c_wlock  = v.wl;
        c_waddr  = {v.wa1, v.wa0};
        c_wdata  = {v.wd1, v.wd0};
        c_rvalid = v.rv;
        c_raddr  = {v.ra1, v.ra0};
    endtask

    task automatic idle_in();
        c_wvalid = 2'b00; c_wlock = 2'b00; c_rvalid = 2'b00;
        c_waddr = '0; c_wdata = '0; c_raddr = '0;
    endtask

    initial begin
        logic [AW-1:0] s_addr [4];
        logic [DW-1:0] s_data [4];

        // rst, wv, wl, wa0, wd0, wa1, wd1, rv, ra0, ra1 | ewr, err, ewaddr, ewdata, eraddr, chk_rdv, erdv, erdata
        // reset holds all grants off
        add(0, 2'b11, 2'b00, 1, 1, 2, 2, 2'b11, 1, 2,  2'b00, 2'b00, 0, 0, 0, 1, 2'b00, 0);
        add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 2'b00, 0);
        // single writers
        add(1, 2'b01, 2'b00, 3, 10, 0, 0, 2'b00, 0, 0,  2'b01, 2'b00, 3, 10, 0, 1, 2'b00, 0);
        add(1, 2'b10, 2'b00, 0, 0, 4, 20, 2'b00, 0, 0,  2'b10, 2'b00, 4, 20, 0, 1, 2'b00, 0);
        // contention, no lock: strict alternation starting with client 0
        add(1, 2'b11, 2'b00, 6, 100, 7, 200, 2'b00, 0, 0,  2'b01, 2'b00, 6, 100, 0, 1, 2'b00, 0);
        add(1, 2'b11, 2'b00, 6, 100, 7, 200, 2'b00, 0, 0,  2'b10, 2'b00, 7, 200, 0, 1, 2'b00, 0);
        add(1, 2'b11, 2'b00, 6, 100, 7, 200, 2'b00, 0, 0,  2'b01, 2'b00, 6, 100, 0, 1, 2'b00, 0);
        add(1, 2'b11, 2'b00, 6, 100, 7, 200, 2'b00, 0, 0,  2'b10, 2'b00, 7, 200, 0, 1, 2'b00, 0);
        add(1, 2'b11, 2'b00, 6, 100, 7, 200, 2'b00, 0, 0,  2'b01, 2'b00, 6, 100, 0, 1, 2'b00, 0);
        add(1, 2'b11, 2'b00, 6, 100, 7, 200, 2'b00, 0, 0,  2'b10, 2'b00, 7, 200, 0, 1, 2'b00, 0);
        // client 0 locked burst capped at 4, then client 1
        add(1, 2'b11, 2'b01, 8, 1, 9, 2, 2'b00, 0, 0,  2'b01, 2'b00, 8, 1, 0, 1, 2'b00, 0);
        add(1, 2'b11, 2'b01, 8, 1, 9, 2, 2'b00, 0, 0,  2'b01, 2'b00, 8, 1, 0, 1, 2'b00, 0);
        add(1, 2'b11, 2'b01, 8, 1, 9, 2, 2'b00, 0, 0,  2'b01, 2'b00, 8, 1, 0, 1, 2'b00, 0);
        add(1, 2'b11, 2'b01, 8, 1, 9, 2, 2'b00, 0, 0,  2'b01, 2'b00, 8, 1, 0, 1, 2'b00, 0);
        add(1, 2'b11, 2'b01, 8, 1, 9, 2, 2'b00, 0, 0,  2'b10, 2'b00, 9, 2, 0, 1, 2'b00, 0);
        add(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 2'b00, 0);
        // preload addr 10 = 10, addr 11 = 5
        add(1, 2'b11, 2'b00, 10, 10, 11, 5, 2'b00, 0, 0,  2'b01, 2'b00, 10, 10, 0, 1, 2'b00, 0);
        add(1, 2'b10, 2'b00, 0, 0, 11, 5, 2'b00, 0, 0,  2'b10, 2'b00, 11, 5, 0, 1, 2'b00, 0);
        // simultaneous reads, responses routed to owner one cycle later
        add(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11, 10, 11,  2'b00, 2'b01, 0, 0, 10, 1, 2'b00, 0);
        add(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b10, 0, 11,  2'b00, 2'b10, 0, 0, 11, 1, 2'b01, 10);
        add(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 2'b10, 5);
        // concurrent write (client 0) and read (client 1)
        add(1, 2'b01, 2'b00, 2, 77, 0, 0, 2'b10, 0, 5,  2'b01, 2'b10, 2, 77, 5, 1, 2'b00, 0);
        add(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 2'b10, 0);
        // lock owner drops valid: grant moves to the other client immediately
        add(1, 2'b11, 2'b10, 12, 3, 13, 4, 2'b00, 0, 0,  2'b10, 2'b00, 13, 4, 0, 1, 2'b00, 0);
        add(1, 2'b01, 2'b00, 12, 3, 13, 4, 2'b00, 0, 0,  2'b01, 2'b00, 12, 3, 0, 1, 2'b00, 0);
        // lock keeps owner over round-robin for its releasing write
        add(1, 2'b01, 2'b01, 12, 3, 13, 4, 2'b00, 0, 0,  2'b01, 2'b00, 12, 3, 0, 1, 2'b00, 0);
        add(1, 2'b11, 2'b00, 12, 3, 13, 4, 2'b00, 0, 0,  2'b01, 2'b00, 12, 3, 0, 1, 2'b00, 0);
        add(1, 2'b11, 2'b00, 12, 3, 13, 4, 2'b00, 0, 0,  2'b10, 2'b00, 13, 4, 0, 1, 2'b00, 0);
        // reset mid-operation: read in flight, client 1 holds a lock
        add(1, 2'b10, 2'b10, 0, 0, 14, 9, 2'b01, 10, 0,  2'b10, 2'b01, 14, 9, 10, 1, 2'b00, 0);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 2'b00, 0);
        // after release client 0 wins both first ties
        add(1, 2'b11, 2'b00, 15, 1, 16, 2, 2'b11, 10, 11,  2'b01, 2'b01, 15, 1, 10, 1, 2'b00, 0);
        add(1, 2'b11, 2'b00, 15, 1, 16, 2, 2'b11, 10, 11,  2'b10, 2'b10, 16, 2, 11, 1, 2'b01, 10);
        add(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 2'b10, 5);

        rst = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            chk($sformatf("r%0d wready", i), 32'(c_wready), 32'(tv[i].ewr));
            chk($sformatf("r%0d rready", i), 32'(c_rready), 32'(tv[i].err));
            chk($sformatf("r%0d wen", i), 32'(ram_wen_0), 32'(|tv[i].ewr));
            if (tv[i].ewr != 2'b00) begin
                chk($sformatf("r%0d waddr", i), 32'(ram_waddr_0), 32'(tv[i].ewaddr));
                chk($sformatf("r%0d wdata", i), ram_wdata_0, tv[i].ewdata);
            end
            if (tv[i].err != 2'b00)
                chk($sformatf("r%0d raddr", i), 32'(ram_raddr_0), 32'(tv[i].eraddr));
            if (tv[i].chk_rdv) begin
                chk($sformatf("r%0d rdata_valid", i), 32'(c_rdata_valid), 32'(tv[i].erdv));
                if (tv[i].erdv != 2'b00)
                    chk($sformatf("r%0d rdata", i), c_rdata, tv[i].erdata);
            end
        end

        // back-to-back reads every cycle from client 0, one result per cycle
        s_addr[0] = 5'd3;  s_data[0] = 32'd10;
        s_addr[1] = 5'd4;  s_data[1] = 32'd20;
        s_addr[2] = 5'd10; s_data[2] = 32'd10;
        s_addr[3] = 5'd11; s_data[3] = 32'd5;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            idle_in();
            if (k < 4) begin
                c_rvalid = 2'b01;
                c_raddr  = {5'd0, s_addr[k]};
            end
            #1;
            if (k < 4) chk($sformatf("stream%0d rready", k), 32'(c_rready), 32'd1);
            if (k > 0) begin
                chk($sformatf("stream%0d rdata_valid", k), 32'(c_rdata_valid), 32'd1);
                chk($sformatf("stream%0d rdata", k), c_rdata, s_data[k-1]);
            end
        end

        // memory contents written through the arbiter
        @(negedge clk);
        idle_in();
        @(negedge clk);
        chk("mem3", mem[3], 32'd10);
        chk("mem4", mem[4], 32'd20);
        chk("mem2", mem[2], 32'd77);
        chk("mem8", mem[8], 32'd1);
        chk("mem14", mem[14], 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
